// File: rtl/riskv_wb_arbiter.sv
// 2:1 Wishbone B4 classic arbiter merging the Riskv iBus (fetch) and dBus (load/store) masters.
// Optional grant watchdog is enabled by defining RISKV_WB_ARB_TIMEOUT_EN.
module riskv_wb_arbiter #(
  parameter int unsigned PRIO_MODE      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] iBusWishbone_ADR,
  input  logic [3:0]  iBusWishbone_SEL,
  input  logic        iBusWishbone_CYC,
  input  logic        iBusWishbone_STB,
  output logic [31:0] iBusWishbone_DAT_MISO,
  output logic        iBusWishbone_ACK,
  output logic        iBusWishbone_ERR,
  input  logic [29:0] dBusWishbone_ADR,
  input  logic [31:0] dBusWishbone_DAT_MOSI,
  input  logic [3:0]  dBusWishbone_SEL,
  input  logic        dBusWishbone_CYC,
  input  logic        dBusWishbone_STB,
  input  logic        dBusWishbone_WE,
  output logic [31:0] dBusWishbone_DAT_MISO,
  output logic        dBusWishbone_ACK,
  output logic        dBusWishbone_ERR,
  output logic [29:0] sWishbone_ADR,
  output logic [31:0] sWishbone_DAT_MOSI,
  output logic [3:0]  sWishbone_SEL,
  output logic        sWishbone_CYC,
  output logic        sWishbone_STB,
  output logic        sWishbone_WE,
  input  logic [31:0] sWishbone_DAT_MISO,
  input  logic        sWishbone_ACK,
  input  logic        sWishbone_ERR
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;  // 1: dBus was served last
  logic   req_i, req_d;
  logic   gnt_i, gnt_d;
  logic   cyc_gnt, s_done, timeout;

  assign req_i   = iBusWishbone_CYC & iBusWishbone_STB;
  assign req_d   = dBusWishbone_CYC & dBusWishbone_STB;
  assign gnt_i   = (state_q == StGntI);
  assign gnt_d   = (state_q == StGntD);
  assign cyc_gnt = (gnt_i & iBusWishbone_CYC) | (gnt_d & dBusWishbone_CYC);
  assign s_done  = sWishbone_ACK | sWishbone_ERR;

`ifdef RISKV_WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cleared while idle so every grant starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (!s_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = cyc_gnt & ~s_done & (cnt_q == CntW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      StIdle: begin
        if (req_i && req_d) begin
          state_d = ((PRIO_MODE != 0) || !last_d_q) ? StGntD : StGntI;
        end else if (req_d) begin
          state_d = StGntD;
        end else if (req_i) begin
          state_d = StGntI;
        end
      end
      StGntI: begin
        // Abort leaves the round-robin history untouched.
        if (!iBusWishbone_CYC) begin
          state_d = StIdle;
        end else if (s_done || timeout) begin
          state_d  = StIdle;
          last_d_d = 1'b0;
        end
      end
      StGntD: begin
        if (!dBusWishbone_CYC) begin
          state_d = StIdle;
        end else if (s_done || timeout) begin
          state_d  = StIdle;
          last_d_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sWishbone_ADR      = '0;
    sWishbone_DAT_MOSI = '0;
    sWishbone_SEL      = '0;
    sWishbone_CYC      = 1'b0;
    sWishbone_STB      = 1'b0;
    sWishbone_WE       = 1'b0;
    if (gnt_i) begin
      sWishbone_ADR = iBusWishbone_ADR;
      sWishbone_SEL = iBusWishbone_SEL;
      sWishbone_CYC = iBusWishbone_CYC & ~timeout;
      sWishbone_STB = iBusWishbone_STB & ~timeout;
    end else if (gnt_d) begin
      sWishbone_ADR      = dBusWishbone_ADR;
      sWishbone_DAT_MOSI = dBusWishbone_DAT_MOSI;
      sWishbone_SEL      = dBusWishbone_SEL;
      sWishbone_CYC      = dBusWishbone_CYC & ~timeout;
      sWishbone_STB      = dBusWishbone_STB & ~timeout;
      sWishbone_WE       = dBusWishbone_WE;
    end
  end

  // Responses are gated by the master's own CYC so an aborted cycle never sees an ACK.
  assign iBusWishbone_ACK      = gnt_i & iBusWishbone_CYC & sWishbone_ACK;
  assign iBusWishbone_ERR      = gnt_i & iBusWishbone_CYC & (sWishbone_ERR | timeout);
  assign dBusWishbone_ACK      = gnt_d & dBusWishbone_CYC & sWishbone_ACK;
  assign dBusWishbone_ERR      = gnt_d & dBusWishbone_CYC & (sWishbone_ERR | timeout);
  assign iBusWishbone_DAT_MISO = sWishbone_DAT_MISO;
  assign dBusWishbone_DAT_MISO = sWishbone_DAT_MISO;

endmodule

// File: tb/tb_riskv_wb_arbiter.sv
// Directed, table-driven bench for riskv_wb_arbiter (round-robin and fixed-priority instances).
module tb_riskv_wb_arbiter;

  localparam logic [29:0] IAdr  = 30'h100;
  localparam logic [3:0]  ISel  = 4'hF;
  localparam logic [29:0] DAdr  = 30'h400;
  localparam logic [31:0] DDat  = 32'hDEADBEEF;
  localparam logic [3:0]  DSel  = 4'b0011;
  localparam logic [31:0] SMiso = 32'hCAFE0001;

  logic        clk;
  logic        reset;
  logic [29:0] iBusWishbone_ADR;
  logic [3:0]  iBusWishbone_SEL;
  logic        iBusWishbone_CYC, iBusWishbone_STB;
  logic [29:0] dBusWishbone_ADR;
  logic [31:0] dBusWishbone_DAT_MOSI;
  logic [3:0]  dBusWishbone_SEL;
  logic        dBusWishbone_CYC, dBusWishbone_STB, dBusWishbone_WE;
  logic [31:0] sWishbone_DAT_MISO;
  logic        sWishbone_ACK, sWishbone_ERR;

  logic [31:0] i_miso, d_miso, p_i_miso, p_d_miso;
  logic        i_ack, i_err, d_ack, d_err, p_i_ack, p_i_err, p_d_ack, p_d_err;
  logic [29:0] s_adr, p_s_adr;
  logic [31:0] s_mosi, p_s_mosi;
  logic [3:0]  s_sel, p_s_sel;
  logic        s_cyc, s_stb, s_we, p_s_cyc, p_s_stb, p_s_we;

  riskv_wb_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .iBusWishbone_ADR(iBusWishbone_ADR), .iBusWishbone_SEL(iBusWishbone_SEL),
    .iBusWishbone_CYC(iBusWishbone_CYC), .iBusWishbone_STB(iBusWishbone_STB),
    .iBusWishbone_DAT_MISO(i_miso), .iBusWishbone_ACK(i_ack), .iBusWishbone_ERR(i_err),
    .dBusWishbone_ADR(dBusWishbone_ADR), .dBusWishbone_DAT_MOSI(dBusWishbone_DAT_MOSI),
    .dBusWishbone_SEL(dBusWishbone_SEL), .dBusWishbone_CYC(dBusWishbone_CYC),
    .dBusWishbone_STB(dBusWishbone_STB), .dBusWishbone_WE(dBusWishbone_WE),
    .dBusWishbone_DAT_MISO(d_miso), .dBusWishbone_ACK(d_ack), .dBusWishbone_ERR(d_err),
    .sWishbone_ADR(s_adr), .sWishbone_DAT_MOSI(s_mosi), .sWishbone_SEL(s_sel),
    .sWishbone_CYC(s_cyc), .sWishbone_STB(s_stb), .sWishbone_WE(s_we),
    .sWishbone_DAT_MISO(sWishbone_DAT_MISO), .sWishbone_ACK(sWishbone_ACK),
    .sWishbone_ERR(sWishbone_ERR)
  );

  riskv_wb_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_p (
    .clk(clk), .reset(reset),
    .iBusWishbone_ADR(iBusWishbone_ADR), .iBusWishbone_SEL(iBusWishbone_SEL),
    .iBusWishbone_CYC(iBusWishbone_CYC), .iBusWishbone_STB(iBusWishbone_STB),
    .iBusWishbone_DAT_MISO(p_i_miso), .iBusWishbone_ACK(p_i_ack), .iBusWishbone_ERR(p_i_err),
    .dBusWishbone_ADR(dBusWishbone_ADR), .dBusWishbone_DAT_MOSI(dBusWishbone_DAT_MOSI),
    .dBusWishbone_SEL(dBusWishbone_SEL), .dBusWishbone_CYC(dBusWishbone_CYC),
    .dBusWishbone_STB(dBusWishbone_STB), .dBusWishbone_WE(dBusWishbone_WE),
    .dBusWishbone_DAT_MISO(p_d_miso), .dBusWishbone_ACK(p_d_ack), .dBusWishbone_ERR(p_d_err),
    .sWishbone_ADR(p_s_adr), .sWishbone_DAT_MOSI(p_s_mosi), .sWishbone_SEL(p_s_sel),
    .sWishbone_CYC(p_s_cyc), .sWishbone_STB(p_s_stb), .sWishbone_WE(p_s_we),
    .sWishbone_DAT_MISO(sWishbone_DAT_MISO), .sWishbone_ACK(sWishbone_ACK),
    .sWishbone_ERR(sWishbone_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g: expected grant seen on the shared mux (0 idle, 1 iBus, 2 dBus)
  typedef struct {
    logic       rst, ic, dc, we, ack, err, chk;
    logic [1:0] g;
    logic       ecyc, eia, eie, eda, ede;
  } vec_t;

  localparam int NVec = 24;
  vec_t vecs[NVec];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and let combinational outputs settle.
  task automatic apply(input logic rst, input logic ic, input logic dc, input logic we,
                       input logic ack, input logic err);
    @(negedge clk);
    reset            = rst;
    iBusWishbone_CYC = ic;
    iBusWishbone_STB = ic;
    dBusWishbone_CYC = dc;
    dBusWishbone_STB = dc;
    dBusWishbone_WE  = we;
    sWishbone_ACK    = ack;
    sWishbone_ERR    = err;
    #1;
  endtask

  initial begin
    logic [29:0] eadr;
    logic [31:0] edat;
    logic [3:0]  esel;
    logic        ewe, ecyc, eerr;
    int          n_pd, n_pi, n_d, n_i;

    iBusWishbone_ADR      = IAdr;
    iBusWishbone_SEL      = ISel;
    dBusWishbone_ADR      = DAdr;
    dBusWishbone_DAT_MOSI = DDat;
    dBusWishbone_SEL      = DSel;
    sWishbone_DAT_MISO    = SMiso;
    reset = 1'b1;
    iBusWishbone_CYC = 1'b0; iBusWishbone_STB = 1'b0;
    dBusWishbone_CYC = 1'b0; dBusWishbone_STB = 1'b0; dBusWishbone_WE = 1'b0;
    sWishbone_ACK = 1'b0; sWishbone_ERR = 1'b0;

    //            rst ic dc we ak er chk g  cyc ia ie da de
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // iBus fetch alone, ACK two cycles after shared CYC rises
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Tie after reset: dBus store first, then iBus after one idle cycle
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Tie with iBus served last -> dBus; ACK+ERR together both forwarded
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    // Tie with dBus served last -> iBus, which then aborts
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Abort kept dBus as last served, so the next tie goes to iBus; finish with ERR only
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // Reset while dBus waits for ACK; late ACK must not be forwarded
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < NVec; k++) begin
      apply(vecs[k].rst, vecs[k].ic, vecs[k].dc, vecs[k].we, vecs[k].ack, vecs[k].err);
      case (vecs[k].g)
        2'd1:    begin eadr = IAdr; edat = '0;   esel = ISel; ewe = 1'b0;       end
        2'd2:    begin eadr = DAdr; edat = DDat; esel = DSel; ewe = vecs[k].we; end
        default: begin eadr = '0;   edat = '0;   esel = '0;   ewe = 1'b0;       end
      endcase
      if (vecs[k].chk) begin
        check($sformatf("v%0d s_cyc", k), 64'(s_cyc), 64'(vecs[k].ecyc));
        check($sformatf("v%0d s_stb", k), 64'(s_stb), 64'(vecs[k].ecyc));
        check($sformatf("v%0d s_we", k), 64'(s_we), 64'(ewe));
        check($sformatf("v%0d s_adr", k), 64'(s_adr), 64'(eadr));
        check($sformatf("v%0d s_mosi", k), 64'(s_mosi), 64'(edat));
        check($sformatf("v%0d s_sel", k), 64'(s_sel), 64'(esel));
        check($sformatf("v%0d i_ack", k), 64'(i_ack), 64'(vecs[k].eia));
        check($sformatf("v%0d i_err", k), 64'(i_err), 64'(vecs[k].eie));
        check($sformatf("v%0d d_ack", k), 64'(d_ack), 64'(vecs[k].eda));
        check($sformatf("v%0d d_err", k), 64'(d_err), 64'(vecs[k].ede));
        check($sformatf("v%0d i_miso", k), 64'(i_miso), 64'(SMiso));
        check($sformatf("v%0d d_miso", k), 64'(d_miso), 64'(SMiso));
      end
    end

    // Both masters request continuously with an always-acking slave.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_pd = 0; n_pi = 0; n_d = 0; n_i = 0;
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      n_pd += int'(p_d_ack); n_pi += int'(p_i_ack);
      n_d  += int'(d_ack);   n_i  += int'(i_ack);
    end
    check("fix_d_acks", 64'(n_pd), 64'd4);
    check("fix_i_acks", 64'(n_pi), 64'd0);
    check("rr_d_acks", 64'(n_d), 64'd2);
    check("rr_i_acks", 64'(n_i), 64'd2);
    n_pi = 0;
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_pi += int'(p_i_ack);
    end
    check("fix_i_after_d_idle", 64'(n_pi), 64'd1);

    // dBus granted, slave silent: watchdog (if built in) fires on the ninth grant cycle.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RISKV_WB_ARB_TIMEOUT_EN
      ecyc = (c >= 1 && c <= 8) || (c == 11);
      eerr = (c == 9);
`else
      ecyc = (c >= 1);
      eerr = 1'b0;
`endif
      check($sformatf("to%0d s_cyc", c), 64'(s_cyc), 64'(ecyc));
      check($sformatf("to%0d d_err", c), 64'(d_err), 64'(eerr));
      check($sformatf("to%0d d_ack", c), 64'(d_ack), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
